// File: rtl/button_event_pkg.sv
// Shared state encoding and default parameter values for the button event generator.
package button_event_pkg;

  localparam int unsigned StateW = 2;
  typedef logic [StateW-1:0] state_t;

  localparam state_t StIdle    = 2'd0;
  localparam state_t StPressed = 2'd1;
  localparam state_t StLong    = 2'd2;

  localparam int unsigned DefLongCycles   = 50000000;
  localparam int unsigned DefRepeatCycles = 10000000;
  localparam int unsigned DefWTimer       = 26;
  localparam int unsigned DefWDur         = 16;

endpackage

// File: rtl/sat_counter.sv
// Up-counter with synchronous clear and enable that sticks at Max instead of wrapping.
module sat_counter #(
  parameter int unsigned      Width = 8,
  parameter logic [Width-1:0] Max   = '1
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             clr_i,
  input  logic             en_i,
  output logic [Width-1:0] count_o
);

  logic [Width-1:0] count_q, count_d;

  always_comb begin
    count_d = count_q;
    if (clr_i) begin
      count_d = '0;
    end else if (en_i && (count_q != Max)) begin
      count_d = count_q + 1'b1;
    end
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      count_q <= '0;
    end else begin
      count_q <= count_d;
    end
  end

  assign count_o = count_q;

endmodule

// File: rtl/button_event_gen.sv
// Turns a debounced button level into press/release/long/repeat pulses plus press duration.
// Auto-repeat is built only when AUTO_REPEAT_EN is defined; otherwise repeat_o is tied 0.
module button_event_gen
  import button_event_pkg::*;
#(
  parameter int unsigned LONG_CYCLES   = DefLongCycles,
  parameter int unsigned REPEAT_CYCLES = DefRepeatCycles,
  parameter int unsigned W_TIMER       = DefWTimer,
  parameter int unsigned W_DUR         = DefWDur
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             button_debounced_i,
  output logic             press_o,
  output logic             release_o,
  output logic             long_o,
  output logic             held_long_o,
  output logic             repeat_o,
  output logic [W_DUR-1:0] duration_o
);

  if (LONG_CYCLES < 2) begin : g_bad_long
    $error("LONG_CYCLES must be at least 2");
  end
  if (REPEAT_CYCLES < 1) begin : g_bad_repeat
    $error("REPEAT_CYCLES must be at least 1");
  end

  state_t           state_q, state_d;
  logic             press_q, press_d;
  logic             release_q, release_d;
  logic             long_q, long_d;
  logic             held_q, held_d;
  logic [W_DUR-1:0] dur_q, dur_d;

  logic [W_DUR-1:0]   hold_cnt;
  logic [W_TIMER-1:0] long_tmr;
  logic               long_hit;

  // Both counters count consecutive high samples; a low sample clears them, so the
  // press edge itself loads 1.
  sat_counter #(
    .Width (W_DUR),
    .Max   ('1)
  ) u_hold_cnt (
    .clk_i   (clk),
    .rst_i   (rst),
    .clr_i   (~button_debounced_i),
    .en_i    (button_debounced_i),
    .count_o (hold_cnt)
  );

  sat_counter #(
    .Width (W_TIMER),
    .Max   (W_TIMER'(LONG_CYCLES))
  ) u_long_tmr (
    .clk_i   (clk),
    .rst_i   (rst),
    .clr_i   (~button_debounced_i),
    .en_i    (button_debounced_i),
    .count_o (long_tmr)
  );

  // The counter will reach LONG_CYCLES on this edge if the input is still high.
  assign long_hit = (long_tmr == W_TIMER'(LONG_CYCLES - 1));

  always_comb begin
    state_d   = state_q;
    press_d   = 1'b0;
    release_d = 1'b0;
    long_d    = 1'b0;
    held_d    = held_q;
    dur_d     = dur_q;
    unique case (state_q)
      StIdle: begin
        if (button_debounced_i) begin
          press_d = 1'b1;
          state_d = StPressed;
        end
      end
      StPressed, StLong: begin
        if (!button_debounced_i) begin
          release_d = 1'b1;
          dur_d     = hold_cnt;
          held_d    = 1'b0;
          state_d   = StIdle;
        end else if ((state_q == StPressed) && long_hit) begin
          long_d  = 1'b1;
          held_d  = 1'b1;
          state_d = StLong;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q   <= StIdle;
      press_q   <= 1'b0;
      release_q <= 1'b0;
      long_q    <= 1'b0;
      held_q    <= 1'b0;
      dur_q     <= '0;
    end else begin
      state_q   <= state_d;
      press_q   <= press_d;
      release_q <= release_d;
      long_q    <= long_d;
      held_q    <= held_d;
      dur_q     <= dur_d;
    end
  end

`ifdef AUTO_REPEAT_EN
  logic [W_TIMER-1:0] rep_tmr_q, rep_tmr_d;
  logic               repeat_q, repeat_d;

  // Held at 0 while PRESSED so it starts from 0 on entry to LONG.
  always_comb begin
    rep_tmr_d = rep_tmr_q;
    repeat_d  = 1'b0;
    if (state_q != StLong) begin
      rep_tmr_d = '0;
    end else if (button_debounced_i) begin
      if (rep_tmr_q == W_TIMER'(REPEAT_CYCLES - 1)) begin
        repeat_d  = 1'b1;
        rep_tmr_d = '0;
      end else begin
        rep_tmr_d = rep_tmr_q + 1'b1;
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rep_tmr_q <= '0;
      repeat_q  <= 1'b0;
    end else begin
      rep_tmr_q <= rep_tmr_d;
      repeat_q  <= repeat_d;
    end
  end

  assign repeat_o = repeat_q;
`else
  assign repeat_o = 1'b0;
`endif

  assign press_o     = press_q;
  assign release_o   = release_q;
  assign long_o      = long_q;
  assign held_long_o = held_q;
  assign duration_o  = dur_q;

endmodule

// File: tb/tb_button_event_gen.sv
// Scoreboard bench: stimulus queues expected pulse records, a negedge monitor pops and checks them.
module tb_button_event_gen;

  localparam int unsigned LongC = 4;
  localparam int unsigned RepC  = 3;
  localparam int unsigned WT    = 8;
  localparam int unsigned WD    = 4;

  logic          clk;
  logic          rst;
  logic          button;
  logic          press_o, release_o, long_o, held_long_o, repeat_o;
  logic [WD-1:0] duration_o;

  button_event_gen #(
    .LONG_CYCLES   (LongC),
    .REPEAT_CYCLES (RepC),
    .W_TIMER       (WT),
    .W_DUR         (WD)
  ) dut (
    .clk                (clk),
    .rst                (rst),
    .button_debounced_i (button),
    .press_o            (press_o),
    .release_o          (release_o),
    .long_o             (long_o),
    .held_long_o        (held_long_o),
    .repeat_o           (repeat_o),
    .duration_o         (duration_o)
  );

  typedef struct {
    int            cyc;
    logic          p;
    logic          r;
    logic          l;
    logic          rp;
    logic          h;
    logic [WD-1:0] dur;
  } ev_t;

  ev_t           exp_q[$];
  int            cyc = 0;
  int            n_vec = 0;
  int            n_bad = 0;
  logic [WD-1:0] exp_dur = '0;

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  always @(posedge clk) cyc <= cyc + 1;

  // Queue the pulses expected from a high run of n edges starting at the next posedge.
  task automatic push_hold(input int n, input bit completes);
    int  base;
    ev_t e;
    base = cyc + 1;
    for (int k = 1; k <= n; k++) begin
      e.cyc = base + k - 1;
      e.p   = (k == 1);
      e.l   = (k == int'(LongC));
      e.r   = 1'b0;
      e.h   = (k >= int'(LongC));
`ifdef AUTO_REPEAT_EN
      e.rp  = (k > int'(LongC)) && (((k - int'(LongC)) % int'(RepC)) == 0);
`else
      e.rp  = 1'b0;
`endif
      e.dur = exp_dur;
      if (e.p || e.l || e.rp) exp_q.push_back(e);
    end
    if (completes) begin
      exp_dur = (n > 15) ? 4'd15 : WD'(n);
      e.cyc = base + n;
      e.p   = 1'b0;
      e.r   = 1'b1;
      e.l   = 1'b0;
      e.rp  = 1'b0;
      e.h   = 1'b0;
      e.dur = exp_dur;
      exp_q.push_back(e);
    end
  endtask

  task automatic check(input string name, input int act, input int req);
    n_vec++;
    if (act != req) begin
      n_bad++;
      $display("FAIL %s: got %0d, expected %0d", name, act, req);
    end
  endtask

  task automatic run_hold(input int n);
    push_hold(n, 1'b1);
    button = 1'b1;
    repeat (n) @(negedge clk);
    button = 1'b0;
    repeat (3) @(negedge clk);
  endtask

  always @(negedge clk) begin
    if (press_o || release_o || long_o || repeat_o) begin
      ev_t e;
      n_vec++;
      if (exp_q.size() == 0) begin
        n_bad++;
        $display("FAIL unexpected_pulse @cyc %0d: got p=%b r=%b l=%b rp=%b, expected none",
                 cyc, press_o, release_o, long_o, repeat_o);
      end else begin
        e = exp_q.pop_front();
        if (e.cyc != cyc || e.p != press_o || e.r != release_o || e.l != long_o ||
            e.rp != repeat_o || e.h != held_long_o || e.dur != duration_o) begin
          n_bad++;
          $display({"FAIL pulse_record: got cyc=%0d p=%b r=%b l=%b rp=%b h=%b dur=%0d, ",
                    "expected cyc=%0d p=%b r=%b l=%b rp=%b h=%b dur=%0d"},
                   cyc, press_o, release_o, long_o, repeat_o, held_long_o, duration_o,
                   e.cyc, e.p, e.r, e.l, e.rp, e.h, e.dur);
        end
      end
    end
  end

  initial begin
    rst    = 1'b1;
    button = 1'b1;
    repeat (3) @(negedge clk);
    check("reset_press", int'(press_o), 0);
    check("reset_release", int'(release_o), 0);
    check("reset_long", int'(long_o), 0);
    check("reset_held", int'(held_long_o), 0);
    check("reset_repeat", int'(repeat_o), 0);
    check("reset_duration", int'(duration_o), 0);

    // Input already high when reset lifts: first edge is a press.
    push_hold(2, 1'b1);
    rst = 1'b0;
    repeat (2) @(negedge clk);
    button = 1'b0;
    repeat (3) @(negedge clk);

    run_hold(1);
    run_hold(3);
    check("held_after_short", int'(held_long_o), 0);
    run_hold(10);
    run_hold(20);
    check("duration_saturated", int'(duration_o), 15);

    // Reset lands after hold edge 5, while in the long state.
    push_hold(5, 1'b0);
    button = 1'b1;
    repeat (5) @(negedge clk);
    #2 rst = 1'b1;
    #1;
    check("midrst_held", int'(held_long_o), 0);
    check("midrst_release", int'(release_o), 0);
    check("midrst_duration", int'(duration_o), 0);
    exp_dur = '0;
    repeat (2) @(negedge clk);
    push_hold(6, 1'b1);
    rst = 1'b0;
    repeat (6) @(negedge clk);
    button = 1'b0;
    repeat (4) @(negedge clk);

    check("pending_expected_pulses", exp_q.size(), 0);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
